// File: rtl/text_cell_fetch_pkg.sv
// Shared constants and types for the text cell fetch block: cell geometry,
// default raster timing and the clear-sweep state encoding.
package text_cell_fetch_pkg;

    localparam int CELL_PX     = 32;
    localparam int HV_W        = 11;
    localparam int ADDR_W      = 10;
    localparam int COLOR_W     = 3;
    localparam int FONT_W      = 32;

    localparam int DEF_COLS    = 32;
    localparam int DEF_ROWS    = 24;
    localparam int DEF_H_TOTAL = 1344;
    localparam int DEF_V_TOTAL = 806;
    localparam int DEF_CODE_W  = 7;

    // Fetch pipeline phases, keyed on the pixel offset inside the current cell
    localparam logic [4:0] OFF_RAM_RD   = 5'd28;
    localparam logic [4:0] OFF_FONT_REQ = 5'd29;
    localparam logic [4:0] OFF_FONT_CAP = 5'd30;
    localparam logic [4:0] OFF_PRESENT  = 5'd31;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    function automatic int cells_per_line(input int h_total);
        return h_total / CELL_PX;
    endfunction

endpackage

// File: rtl/text_cell_fetch_if.sv
// Game-logic write port of the text buffer: cell writes with a ready handshake
// plus the whole-buffer clear request and its busy flag.
interface text_cell_fetch_if #(
    parameter int CODE_W = 7
) ();
    logic                wr_en;
    logic [9:0]          wr_addr;
    logic [CODE_W+2:0]   wr_data;
    logic                wr_ready;
    logic                clr;
    logic                busy;

    modport master (
        output wr_en, wr_addr, wr_data, clr,
        input  wr_ready, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, clr,
        output wr_ready, busy
    );
endinterface

// File: rtl/text_cell_fetch_ram.sv
// Single-port text buffer with synchronous read; contents are not reset, the
// clear sweep in the top level is responsible for initialising them.
module text_buffer_ram #(
    parameter int DEPTH = 768,
    parameter int WIDTH = 10,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/text_cell_fetch.sv
// Text overlay cell fetcher: prefetches the next cell's glyph row during the last
// four pixels of the current cell and swaps it onto line_data/color at offset 0.
module text_cell_fetch
    import text_cell_fetch_pkg::*;
#(
    parameter int COLS    = DEF_COLS,
    parameter int ROWS    = DEF_ROWS,
    parameter int H_TOTAL = DEF_H_TOTAL,
    parameter int V_TOTAL = DEF_V_TOTAL,
    parameter int CODE_W  = DEF_CODE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [HV_W-1:0]     hcount,
    input  logic [HV_W-1:0]     vcount,
    text_cell_fetch_if.slave    bus,
    output logic [CODE_W+4:0]   font_addr,
    input  logic [FONT_W-1:0]   font_row,
    output logic [FONT_W-1:0]   line_data,
    output logic [COLOR_W-1:0]  color
);
    localparam int ENTRY_W = CODE_W + COLOR_W;
    localparam int N_CELLS = COLS * ROWS;
    localparam int H_CELLS = cells_per_line(H_TOTAL);

    logic [4:0]          off;
    logic                is_fetch;
    logic [5:0]          col_raw;
    logic [5:0]          col_t;
    logic [HV_W-1:0]     v_next;
    logic [HV_W-1:0]     line_t;
    logic [5:0]          row_t;
    logic                oob_t;
    logic [ADDR_W-1:0]   fetch_addr;

    logic                ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [ENTRY_W-1:0]  ram_wdata;
    logic [ENTRY_W-1:0]  ram_rdata;
    logic                wr_in_range;

    clr_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;

    logic                oob_s1_q;
    logic [4:0]          glyph_s1_q;
    logic                oob_s2_q;
    logic [COLOR_W-1:0]  color_s2_q;
    logic [FONT_W-1:0]   pending_line_q;
    logic [COLOR_W-1:0]  pending_color_q;
    logic [FONT_W-1:0]   line_data_q;
    logic [COLOR_W-1:0]  color_q;

    assign off      = hcount[4:0];
    assign is_fetch = (off == OFF_RAM_RD);

    // Target is the cell after the current one; the last cell of a line targets
    // column 0 of the next line, wrapping the frame at V_TOTAL.
    always_comb begin
        col_raw = hcount[10:5] + 6'd1;
        v_next  = vcount + 11'd1;
        col_t   = col_raw;
        line_t  = vcount;
        if (col_raw == 6'(H_CELLS)) begin
            col_t  = '0;
            line_t = (v_next == HV_W'(V_TOTAL)) ? '0 : v_next;
        end
        row_t      = line_t[10:5];
        oob_t      = (int'(col_t) >= COLS) || (int'(row_t) >= ROWS);
        fetch_addr = oob_t ? '0 : ADDR_W'(int'(row_t) * COLS + int'(col_t));
    end

    assign wr_in_range = (int'(bus.wr_addr) < N_CELLS);

    // The display read owns the RAM port at offset 28; otherwise the sweep or a
    // game-logic write may use it.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = fetch_addr;
        ram_wdata = '0;
        if (!is_fetch) begin
            if (state_q == ST_CLEAR) begin
                ram_we   = 1'b1;
                ram_addr = clr_addr_q;
            end else if (bus.wr_en && !bus.clr && wr_in_range) begin
                ram_we    = 1'b1;
                ram_addr  = bus.wr_addr;
                ram_wdata = bus.wr_data;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.clr) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            ST_CLEAR: begin
                if (bus.clr) begin
                    clr_addr_d = '0;
                end else if (!is_fetch) begin
                    if (clr_addr_q == ADDR_W'(N_CELLS - 1)) begin
                        state_d    = ST_IDLE;
                        clr_addr_d = '0;
                    end else begin
                        clr_addr_d = clr_addr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                clr_addr_d = '0;
            end
        endcase
    end

    assign bus.busy     = (state_q == ST_CLEAR);
    assign bus.wr_ready = (state_q == ST_IDLE) && !is_fetch;

    text_buffer_ram #(
        .DEPTH (N_CELLS),
        .WIDTH (ENTRY_W),
        .AW    (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign font_addr = {ram_rdata[CODE_W-1:0], glyph_s1_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_CLEAR;
            clr_addr_q      <= '0;
            oob_s1_q        <= 1'b0;
            glyph_s1_q      <= '0;
            oob_s2_q        <= 1'b0;
            color_s2_q      <= '0;
            pending_line_q  <= '0;
            pending_color_q <= '0;
            line_data_q     <= '0;
            color_q         <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            if (off == OFF_RAM_RD) begin
                oob_s1_q   <= oob_t;
                glyph_s1_q <= line_t[4:0];
            end
            // RAM output is only meaningful this cycle, so colour is kept here
            if (off == OFF_FONT_REQ) begin
                oob_s2_q   <= oob_s1_q;
                color_s2_q <= ram_rdata[ENTRY_W-1:CODE_W];
            end
            if (off == OFF_FONT_CAP) begin
                pending_line_q  <= oob_s2_q ? '0 : font_row;
                pending_color_q <= oob_s2_q ? '0 : color_s2_q;
            end
            if (off == OFF_PRESENT) begin
                line_data_q <= pending_line_q;
                color_q     <= pending_color_q;
            end
        end
    end

    assign line_data = line_data_q;
    assign color     = color_q;

endmodule
